// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache refill/writeback interface.
// Define CACHE_MEM_RESP_GAP_EN to insert a bubble between line beats.
module cache_mem_responder #(
    parameter int MEM_AW     = 12,
    parameter int RD_LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd_req,
    input  logic [2:0]   rd_type,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic         ret_last,
    output logic [31:0]  ret_data,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST
    } state_t;

    localparam int DEPTH = 1 << MEM_AW;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_lat;
    logic [3:0]          w_lat_nxt;
    logic [1:0]          r_beat;
    logic [1:0]          w_beat_nxt;
    logic [1:0]          r_last_beat;
    logic [1:0]          w_last_beat_nxt;
    logic [MEM_AW-1:0]   r_base;
    logic [MEM_AW-1:0]   w_base_nxt;
    logic                r_gap;
    logic                w_gap_nxt;
    logic                r_valid;
    logic                w_valid_nxt;
    logic                r_last;
    logic                w_last_nxt;
    logic [31:0]         r_data;
    logic                w_rd_en;
    logic [1:0]          w_rd_beat;
    logic                w_idle;
    logic                w_rd_hs;
    logic                w_wr_hs;
    logic                w_rd_line;
    logic                w_wr_line;
    logic [MEM_AW-1:0]   w_wr_idx;
    logic [MEM_AW-1:0]   w_rd_idx;
    logic                w_unused;

    logic [31:0]         r_mem [DEPTH];

    assign w_idle    = (r_state == S_IDLE) && !reset;
    assign rd_rdy    = w_idle;
    assign wr_rdy    = w_idle;
    assign w_rd_hs   = rd_req && w_idle;
    assign w_wr_hs   = wr_req && w_idle;
    assign w_rd_line = (rd_type == 3'b100);
    assign w_wr_line = (wr_type == 3'b100);
    assign w_wr_idx  = wr_addr[MEM_AW+1:2];
    assign w_rd_idx  = r_base + MEM_AW'(w_rd_beat);

    assign ret_valid = r_valid;
    assign ret_last  = r_last;
    assign ret_data  = r_data;

    // Address bits outside the word index are ignored (aliasing).
    assign w_unused  = ^{rd_addr[31:MEM_AW+2], rd_addr[1:0],
                         wr_addr[31:MEM_AW+2], wr_addr[1:0]};

    always_comb begin
        w_state_nxt     = r_state;
        w_lat_nxt       = r_lat;
        w_beat_nxt      = r_beat;
        w_last_beat_nxt = r_last_beat;
        w_base_nxt      = r_base;
        w_gap_nxt       = 1'b0;
        w_valid_nxt     = 1'b0;
        w_last_nxt      = 1'b0;
        w_rd_en         = 1'b0;
        w_rd_beat       = r_beat;
        unique case (r_state)
            S_IDLE: begin
                if (w_rd_hs) begin
                    w_state_nxt     = S_WAIT;
                    w_lat_nxt       = 4'(RD_LATENCY - 1);
                    w_beat_nxt      = 2'd0;
                    w_last_beat_nxt = w_rd_line ? 2'd3 : 2'd0;
                    w_base_nxt      = w_rd_line
                                    ? {rd_addr[MEM_AW+1:4], 2'b00}
                                    : rd_addr[MEM_AW+1:2];
                end
            end
            S_WAIT: begin
                if (r_lat == 4'd0) begin
                    w_state_nxt = S_BURST;
                    w_rd_en     = 1'b1;
                    w_rd_beat   = 2'd0;
                    w_beat_nxt  = 2'd0;
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = (r_last_beat == 2'd0);
                end else begin
                    w_lat_nxt = r_lat - 4'd1;
                end
            end
            S_BURST: begin
                if (r_beat == r_last_beat && !r_gap) begin
                    w_state_nxt = S_IDLE;
`ifdef CACHE_MEM_RESP_GAP_EN
                end else if (!r_gap) begin
                    w_gap_nxt = 1'b1;
`endif
                end else begin
                    w_rd_en     = 1'b1;
                    w_rd_beat   = r_beat + 2'd1;
                    w_beat_nxt  = r_beat + 2'd1;
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = ((r_beat + 2'd1) == r_last_beat);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_lat       <= 4'd0;
            r_beat      <= 2'd0;
            r_last_beat <= 2'd0;
            r_base      <= '0;
            r_gap       <= 1'b0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_data      <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_lat       <= w_lat_nxt;
            r_beat      <= w_beat_nxt;
            r_last_beat <= w_last_beat_nxt;
            r_base      <= w_base_nxt;
            r_gap       <= w_gap_nxt;
            r_valid     <= w_valid_nxt;
            r_last      <= w_last_nxt;
            if (w_rd_en) begin
                r_data <= r_mem[w_rd_idx];
            end
        end
    end

    // RAM is never cleared; writes only land in IDLE, before any read beat.
    always_ff @(posedge clk) begin
        if (w_wr_hs) begin
            if (w_wr_line) begin
                for (int i = 0; i < 4; i++) begin
                    r_mem[{w_wr_idx[MEM_AW-1:2], 2'(i)}] <= wr_data[32*i +: 32];
                end
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_wstrb[b]) begin
                        r_mem[w_wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Randomised and directed bench for cache_mem_responder.
// Expected beats come from a word-indexed model of the backing RAM.
module tb_cache_mem_responder;

    localparam int MEM_AW = 12;
    localparam int LAT    = 2;
    localparam int DEPTH  = 1 << MEM_AW;
`ifdef CACHE_MEM_RESP_GAP_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         rd_req = 1'b0;
    logic [2:0]   rd_type = 3'd0;
    logic [31:0]  rd_addr = 32'd0;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         wr_req = 1'b0;
    logic [2:0]   wr_type = 3'd0;
    logic [31:0]  wr_addr = 32'd0;
    logic [3:0]   wr_wstrb = 4'd0;
    logic [127:0] wr_data = '0;
    logic         wr_rdy;

    int vec  = 0;
    int miss = 0;

    bit [31:0] m_mem [int];
    int        lines [$];

    cache_mem_responder #(
        .MEM_AW     (MEM_AW),
        .RD_LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_req    (rd_req),
        .rd_type   (rd_type),
        .rd_addr   (rd_addr),
        .rd_rdy    (rd_rdy),
        .ret_valid (ret_valid),
        .ret_last  (ret_last),
        .ret_data  (ret_data),
        .wr_req    (wr_req),
        .wr_type   (wr_type),
        .wr_addr   (wr_addr),
        .wr_wstrb  (wr_wstrb),
        .wr_data   (wr_data),
        .wr_rdy    (wr_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int widx(bit [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic model_write(bit [2:0] t, bit [31:0] a, bit [3:0] s,
                               bit [127:0] d);
        int i;
        bit [31:0] w;
        i = widx(a);
        if (t == 3'b100) begin
            for (int j = 0; j < 4; j++) m_mem[(i / 4) * 4 + j] = d[32*j +: 32];
        end else begin
            w = m_mem.exists(i) ? m_mem[i] : 32'd0;
            for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
            m_mem[i] = w;
        end
    endtask

    // Called just after a falling edge with the DUT idle; returns likewise.
    task automatic xact(string tag, bit dw, bit [2:0] wt, bit [31:0] wa,
                        bit [3:0] ws, bit [127:0] wd,
                        bit dr, bit [2:0] rt, bit [31:0] ra);
        int nb, base, n, beat;
        bit ev;
        bit [31:0] ex [4];
        wr_req = dw; wr_type = wt; wr_addr = wa; wr_wstrb = ws; wr_data = wd;
        rd_req = dr; rd_type = rt; rd_addr = ra;
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        if (dw) model_write(wt, wa, ws, wd);
        if (!dr) begin
            @(negedge clk);
            chk({tag, ".wr_rdy"}, {31'd0, wr_rdy}, 32'd1);
            return;
        end
        nb   = (rt == 3'b100) ? 4 : 1;
        base = (rt == 3'b100) ? (widx(ra) / 4) * 4 : widx(ra);
        for (int j = 0; j < nb; j++) ex[j] = m_mem[base + j];
        n = LAT + (nb - 1) * STEP;
        for (int k = 0; k <= n + 1; k++) begin
            @(negedge clk);
            ev   = (k >= LAT) && (k <= n) && ((k - LAT) % STEP == 0);
            beat = (k - LAT) / STEP;
            chk({tag, ".valid"}, {31'd0, ret_valid}, {31'd0, ev});
            chk({tag, ".last"}, {31'd0, ret_last},
                {31'd0, ev && (beat == nb - 1)});
            chk({tag, ".rd_rdy"}, {31'd0, rd_rdy}, {31'd0, k == n + 1});
            chk({tag, ".wr_rdy"}, {31'd0, wr_rdy}, {31'd0, k == n + 1});
            if (ev) chk({tag, ".data"}, ret_data, ex[beat]);
        end
    endtask

    function automatic bit [31:0] alias_addr(int word);
        bit [31:0] a;
        a = $urandom;
        a[MEM_AW+1:0] = {word[MEM_AW-1:0], a[1:0]};
        return a;
    endfunction

    initial begin
        bit [2:0]   nl [7];
        bit [127:0] d;
        int         op, ln, wd;
        nl = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst.valid", {31'd0, ret_valid}, 32'd0);
            chk("rst.last", {31'd0, ret_last}, 32'd0);
            chk("rst.data", ret_data, 32'd0);
            chk("rst.rdy", {30'd0, rd_rdy, wr_rdy}, 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rel.rdy", {30'd0, rd_rdy, wr_rdy}, 32'd3);

        xact("lw", 1, 3'b100, 32'h1230, 4'hF,
             {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000},
             0, 3'd0, 32'd0);
        xact("lr", 0, 3'd0, 32'd0, 4'd0, '0, 1, 3'b100, 32'h1238);
        xact("lr_alias", 0, 3'd0, 32'd0, 4'd0, '0, 1, 3'b100, 32'h8000_1230);
        xact("ww", 1, 3'b010, 32'h1234, 4'hF, 128'hCCCC_0001,
             0, 3'd0, 32'd0);
        xact("pw", 1, 3'b010, 32'h1234, 4'b0101, 128'h1122_3344,
             0, 3'd0, 32'd0);
        chk("pw.model", m_mem[widx(32'h1234)], 32'hCC22_0044);
        xact("sr", 0, 3'd0, 32'd0, 4'd0, '0, 1, 3'b010, 32'h1234);
        xact("sim", 1, 3'b100, 32'h40, 4'h0, {32'd4, 32'd3, 32'd2, 32'd1},
             1, 3'b100, 32'h40);

        rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h40;
        @(posedge clk);
        #1 rd_req = 1'b0;
        repeat (LAT + 2 * STEP) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("mid.beat2", ret_data, 32'd3);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("mid.valid", {31'd0, ret_valid}, 32'd0);
            chk("mid.last", {31'd0, ret_last}, 32'd0);
            chk("mid.rdy", {30'd0, rd_rdy, wr_rdy}, 32'd3);
        end
        xact("post", 0, 3'd0, 32'd0, 4'd0, '0, 1, 3'b100, 32'h1230);
        xact("post1", 0, 3'd0, 32'd0, 4'd0, '0, 1, 3'b001, 32'h41);

        lines.push_back(widx(32'h1230));
        lines.push_back(widx(32'h40));
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 4);
            ln = lines[$urandom_range(0, lines.size() - 1)];
            wd = ln + $urandom_range(0, 3);
            d  = {$urandom, $urandom, $urandom, $urandom};
            case (op)
                0: begin
                    wd = $urandom_range(0, DEPTH - 1);
                    lines.push_back((wd / 4) * 4);
                    xact("r.lw", 1, 3'b100, alias_addr(wd), 4'hF, d,
                         0, 3'd0, 32'd0);
                end
                1: xact("r.pw", 1, nl[$urandom_range(0, 6)], alias_addr(wd),
                        4'($urandom), d, 0, 3'd0, 32'd0);
                2: xact("r.lr", 0, 3'd0, 32'd0, 4'd0, '0,
                        1, 3'b100, alias_addr(wd));
                3: xact("r.sr", 0, 3'd0, 32'd0, 4'd0, '0,
                        1, nl[$urandom_range(0, 6)], alias_addr(wd));
                default: xact("r.sim", 1, 3'b100, alias_addr(ln), 4'h0, d,
                              1, 3'b100, alias_addr(wd));
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
- Responder (memory side) for the cache refill/writeback interface: accepts the cache's rd_req/wr_req requests, serves line reads (4 beats) and single-word reads from an internal word-addressed backing RAM, and commits line or partial-word writes.
- Serves as the bench-side and FPGA-side memory model for the instruction and data caches, in place of the AXI bridge.
- Has a configurable read latency so that cache MISS/REPLACE timing can be stressed.

Parameters:
- MEM_AW, 12, log2 of RAM depth in 32-bit words; word index = addr[MEM_AW+1:2]; higher address bits are ignored (aliasing).
- RD_LATENCY, 2, cycles from read handshake edge to first ret_valid; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- rd_req  in  1  read request
- rd_type  in  3  000 byte, 001 half, 010 word, 100 cache line (4 words)
- rd_addr  in  32  read byte address
- rd_rdy  out  1  responder can accept a read
- ret_valid  out  1  return beat valid
- ret_last  out  1  final beat of current read
- ret_data  out  32  return beat data
- wr_req  in  1  write request
- wr_type  in  3  encoding as rd_type
- wr_addr  in  32  write byte address
- wr_wstrb  in  4  byte enables; used only for wr_type 000/001/010
- wr_data  in  128  line data; word i = bits [32i+31:32i]; non-line writes use [31:0]
- wr_rdy  out  1  responder can accept a write

Behaviour:
- Clock is clk; reset is synchronous and active-high, named reset.
- FSM states: IDLE, WAIT, BURST. Reset forces IDLE, latency counter = 0, beat counter = 0, ret_valid = 0, ret_last = 0, ret_data = 0. RAM contents are not cleared by reset.
- rd_rdy = wr_rdy = (state == IDLE) && !reset. Both are 0 in WAIT and BURST.
- Read handshake is rd_req && rd_rdy. Write handshake is wr_req && wr_rdy. Requests without rdy are ignored; the requester holds them.
- Read accept:
  - Latch the word address and beat count: 4 for type 100, 1 otherwise.
  - Line reads start at word addr[MEM_AW+1:4],00 regardless of addr[3:2]. Beats are returned in order word0..word3.
  - Next state is WAIT; the latency counter is loaded with RD_LATENCY-1.
- WAIT: the counter decrements each cycle. When it reaches 0, go to BURST. With RD_LATENCY=1, go directly to BURST.
- Read timing: handshake edge at cycle T gives the first ret_valid=1 during cycle T+RD_LATENCY. Line beats follow on consecutive cycles.
- BURST:
  - ret_valid, ret_last and ret_data are registered outputs.
  - ret_data = RAM[base+beat] read at the preceding edge.
  - ret_last = 1 only on the final beat (beat 3 for a line, beat 0 for a single read).
  - The cycle after the last beat: state is IDLE and rd_rdy = 1.
- Single reads return the whole aligned word. Byte and halfword selection is left to the requester.
- Write accept commits at the handshake edge; there is no response channel.
  - Line write: 4 words to addr[MEM_AW+1:4],i, all bytes.
  - Other types: one word at addr[MEM_AW+1:2], bytes gated by wr_wstrb. wr_wstrb = 0000 is a legal no-op.
- Simultaneous rd_req and wr_req in IDLE: both are accepted in the same cycle. The write commits first, so a read of the same line returns the new data.
- Writes during WAIT/BURST are impossible because wr_rdy = 0.
- Undefined rd_type or wr_type (011, 101-111) is treated as word (010).
- Reset mid-WAIT or mid-BURST aborts the read. The cycle after reset deasserts: ret_valid = 0, state IDLE, rdy = 1. No partial beats are resumed.

Optional Feature:
- Macro: CACHE_MEM_RESP_GAP_EN.
- When defined: in BURST, a one-cycle bubble (ret_valid = 0, ret_data held) is inserted between consecutive line beats. A line read occupies 7 cycles from the first beat; single-word reads are unchanged.
- When undefined: beats are back-to-back, as described above.

Test Plan:
- Reset asserted 3 cycles, then released → ret_valid = ret_last = 0 and ret_data = 0 throughout reset; rd_rdy = wr_rdy = 1 on the first cycle after release.
- Line write, then line read:
  - Stimulus: wr_type = 100, wr_addr = 0x0000_1230, wr_data = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000}; then rd_type = 100, rd_addr = 0x0000_1238 handshaken at cycle T.
  - Response (RD_LATENCY = 2): beats at T+2..T+5 carry AAAA_0000, BBBB_0001, CCCC_0002, DDDD_0003; ret_last only at T+5; rd_rdy = 1 at T+6.
- Partial write, then single read:
  - Stimulus: wr_type = 010, wr_addr = 0x1234, wr_wstrb = 0101, wr_data[31:0] = 0x1122_3344 over an old word of 0xCCCC_0001; then rd_type = 010, rd_addr = 0x1234.
  - Response: one beat 0xCC22_0044 with ret_valid = ret_last = 1.
- Simultaneous rd_req (line 0x40) and wr_req (line 0x40, data words 1, 2, 3, 4) in IDLE → both accepted in the same cycle; read beats return 1, 2, 3, 4; wr_rdy = 0 until after the last beat.
- Reset pulse during beat 2 of a line read → ret_valid = 0 the cycle after reset; no ret_last seen; the next read works normally.
- With CACHE_MEM_RESP_GAP_EN defined: line read → ret_valid pattern is 1010101 starting at T+RD_LATENCY; ret_last on the 7th cycle.
